// File: rtl/serial_arith_if.sv
// Operand/result bundle for serial_arith_seq: the requester drives start/op_sub/a/b,
// the sequencer returns busy/done, the result, carry-out, flags and its FSM state.
interface serial_arith_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is sampled only while busy=0 (IDLE or FIN); a sampled start
  // captures op_sub/a/b on that edge. done pulses for one cycle when result,
  // cout and flags become valid; they then hold until the next accepted start.
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic [1:0]       dbg_state;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, flag_z, flag_n, flag_v, dbg_state
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, flag_z, flag_n, flag_v, dbg_state
  );
endinterface

// File: rtl/serial_arith_seq.sv
// Bit-serial add/subtract: one full-adder cell reused LSB-first over WIDTH cycles.
// Define SERIAL_ARITH_FLAGS_EN to build the zero/negative/overflow flag logic.
module serial_arith_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_arith_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic w_s;
  logic w_c;
  logic w_accept;
  logic w_last;

  // The single full-adder cell; operands shift right so bit 0 is always current.
  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_accept = (r_state != RUN) && bus.start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          r_done <= 1'b0;
          if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with op_sub.
            r_a      <= bus.a;
            r_b      <= bus.op_sub ? ~bus.b : bus.b;
            r_carry  <= bus.op_sub;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_result[r_cnt] <= w_s;
          r_carry         <= w_c;
          r_a             <= r_a >> 1;
          r_b             <= r_b >> 1;
          if (w_last) begin
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ARITH_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;
  logic r_flag_v;

  // Flags are resolved on the last bit: the MSB sum is still on w_s, and the
  // lower result bits are already in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_accept) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_last) begin
      r_flag_z <= ~w_s && (r_result[WIDTH-2:0] == '0);
      r_flag_n <= w_s;
      r_flag_v <= r_carry ^ w_c;
    end
  end

  assign bus.flag_z = r_flag_z;
  assign bus.flag_n = r_flag_n;
  assign bus.flag_v = r_flag_v;
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_n = 1'b0;
  assign bus.flag_v = 1'b0;
`endif

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_arith_seq.sv
// Bench for serial_arith_seq: directed corner cases plus random traffic, every
// cycle compared against an arithmetic reference model of the sequencer.
module tb_serial_arith_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sim_end = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  serial_arith_if #(.WIDTH(W)) bus ();

  serial_arith_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic fl(input logic x);
`ifdef SERIAL_ARITH_FLAGS_EN
    return x;
`else
    return 1'b0 & x;
`endif
  endfunction

  // Reference arithmetic from plain integers: returns {cout, z, n, v, result}.
  function automatic logic [W+3:0] ref_calc(input logic op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [63:0] ua, ub, us;
    longint      sa, sb, ss;
    logic [W-1:0] res;
    logic c, z, n, v;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    us = op ? ua - ub : ua + ub;
    ss = op ? sa - sb : sa + sb;
    res = us[W-1:0];
    c = op ? (ua >= ub) : (ua + ub >= (64'd1 << W));
    z = (res == '0);
    n = res[W-1];
    v = (ss > longint'((64'd1 << (W - 1)) - 1)) || (ss < -longint'(64'd1 << (W - 1)));
    return {c, fl(z), fl(n), fl(v), res};
  endfunction

  // Reference model: counts edges of an accepted operation.
  logic [W-1:0] exp_q[$];
  logic [3:0]   aux_q[$];
  int           left = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_cout = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [W+3:0] r;
    if (!rst_n) begin
      left = 0;
      m_done = 1'b0;
      m_result = '0;
      {m_cout, m_z, m_n, m_v} = 4'b0;
      exp_q.delete();
      aux_q.delete();
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1'b1;
          if (exp_q.size() > 0) begin
            m_result = exp_q.pop_front();
            {m_cout, m_z, m_n, m_v} = aux_q.pop_front();
          end
        end
      end else if (bus.start) begin
        left = W;
        r = ref_calc(bus.op_sub, bus.a, bus.b);
        exp_q.push_back(r[W-1:0]);
        aux_q.push_back(r[W+3:W]);
      end
    end
    m_busy = (left > 0);
  end

  // Per-cycle compare; result and flags are only meaningful while not busy.
  initial begin
    while (!sim_end) begin
      @(posedge clk);
      #2;
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      if (!m_busy) begin
        chk("result", bus.result, m_result);
        chk("cout", bus.cout, m_cout);
        chk("flags", {bus.flag_z, bus.flag_n, bus.flag_v}, {m_z, m_n, m_v});
      end
    end
  end

  // Drive one operation and check its latency and hand-computed outputs.
  // immediate: start in the current (FIN) cycle; inject_at: cycle of a stray start.
  task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_res,
                        input logic e_c, input logic e_z, input logic e_n, input logic e_v,
                        input bit immediate, input int inject_at);
    int cnt;
    if (!immediate) @(negedge clk);
    bus.start = 1'b1;
    bus.op_sub = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    cnt = 0;
    while (cnt <= 200) begin
      @(negedge clk);
      cnt++;
      if (bus.done) break;
      if (cnt == inject_at) begin
        bus.start = 1'b1;
        bus.op_sub = ~op;
        bus.a = $urandom;
        bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({name, "_latency"}, 64'(cnt), 64'(W));
    chk({name, "_result"}, bus.result, e_res);
    chk({name, "_cout"}, bus.cout, e_c);
    chk({name, "_flags"}, {bus.flag_z, bus.flag_n, bus.flag_v}, {fl(e_z), fl(e_n), fl(e_v)});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit saw_done;
    bus.start = 1'b0;
    bus.op_sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_result", bus.result, '0);
    chk("reset_cout_flags", {bus.cout, bus.flag_z, bus.flag_n, bus.flag_v}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add5_3", 1'b0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_op("sub3_5", 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_op("ignore_start", 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    run_op("b2b_first", 1'b1, 32'd100, 32'd1, 32'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("b2b_second", 1'b0, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_op("sub_equal", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_sub = 1'b0;
    bus.a = 32'hFFFF_0000;
    bus.b = 32'h0000_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_result", bus.result, '0);
    chk("midreset_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 8) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("midreset_no_done", saw_done, 1'b0);
    run_op("after_reset", 1'b0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Random traffic, including starts that land while busy.
    repeat (4000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 4) == 0);
      bus.op_sub = 1'($urandom_range(0, 1));
      bus.a = pick();
      bus.b = pick();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);
    sim_end = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_arith_seq.md
SERIAL_ARITH_SEQ -- requirements
Module: serial_arith_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (range 2..64).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; captured with start.
REQ-006 a  input  WIDTH  first operand; captured with start.
REQ-007 b  input  WIDTH  second operand; captured with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking that result and flags are valid.
REQ-010 result  output  WIDTH  sum or difference; held until the next accepted start.
REQ-011 cout  output  1  final carry-out; for subtraction, 1 means no borrow.
REQ-012 flag_z, flag_n, flag_v  output  1 each  zero, negative and signed-overflow flags.

Function
REQ-013 The datapath shall consist of exactly one 1-bit full-adder cell (s = a^b^cin, c = majority) plus a carry register, reused once per bit.
REQ-014 FSM states shall be IDLE, RUN and FIN.
- IDLE->RUN on start=1.
- RUN->FIN after the bit counter reaches WIDTH-1.
- FIN->RUN on start=1; otherwise FIN->IDLE.
REQ-015 On an accepted start, the block shall:
- load operand shift registers;
- load the carry register with op_sub;
- invert b when op_sub=1;
- clear the bit counter and the result register.
REQ-016 In RUN, one bit shall be processed per cycle, LSB first: sum bit into result[counter], carry register updated, counter incremented.
REQ-017 Latency: if start is accepted at edge E0, bits are processed on edges E1..E_WIDTH. done=1 and result is valid in the cycle after E_WIDTH, i.e. exactly WIDTH cycles after acceptance.
REQ-018 busy shall be 1 from the cycle after acceptance through the last RUN cycle, and 0 in IDLE and FIN.
REQ-019 done shall be 1 only in FIN, for exactly one cycle.
REQ-020 start while busy=1 shall be ignored with no effect on operands, counter or result.
REQ-021 start asserted in the FIN cycle shall be accepted (back-to-back operations with no idle cycle).
REQ-022 cout shall equal the carry register after bit WIDTH-1.
REQ-023 flag_v shall equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 flag_n shall equal result[WIDTH-1]; flag_z shall be 1 iff result==0.
REQ-025 The bit counter shall be ceil(log2(WIDTH)) bits wide and shall not wrap beyond WIDTH-1 within one operation.
REQ-026 result, cout and all flags shall hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst_n=0 shall immediately force:
- state IDLE, busy=0, done=0;
- result=0, cout=0, flag_z=0, flag_n=0, flag_v=0;
- counter=0, carry register=0.
REQ-028 Reset asserted mid-operation shall abort the operation; no done pulse shall follow.
REQ-029 After rst_n deasserts, the first start shall be accepted on the first rising edge where start=1.

Configuration
REQ-030 Macro SERIAL_ARITH_FLAGS_EN shall control the flag logic.
- Defined: flag_z, flag_n and flag_v are computed per REQ-023/024.
- Undefined: flag_z, flag_n and flag_v are tied to 0 and their logic is omitted.
- cout and all port lists are identical in both builds.

Verification
REQ-031 WIDTH=32, a=5, b=3, op_sub=0, start one cycle -> done exactly 32 cycles later; result=8, cout=0, z=0, v=0.
REQ-032 a=0xFFFFFFFF, b=1, op_sub=0 -> result=0, cout=1, flag_z=1, flag_v=0.
REQ-033 a=3, b=5, op_sub=1 -> result=0xFFFFFFFE, cout=0, flag_n=1; then a=0x7FFFFFFF, b=1, op_sub=0 -> result=0x80000000, flag_v=1.
REQ-034 start pulsed with new operands at cycle 10 of a RUN -> ignored; original result delivered. start held during FIN -> second operation begins with no idle cycle; its done arrives WIDTH cycles later.
REQ-035 rst_n pulsed low at cycle 16 of a RUN -> busy=0 and result=0 immediately, no done pulse; next start completes correctly.
REQ-036 Build without SERIAL_ARITH_FLAGS_EN, rerun REQ-032 -> flag_z=0, cout=1, result=0.
